inst_fetcher: RTL and testbench

- Instruction-fetch stage directly upstream of the memory controller's instruction port.
- Holds the PC and issues one 32-bit fetch request at a time to the memory controller.
- Fills an optional direct-mapped instruction cache.
- Delivers {pc, inst} to the instruction queue. Redirects on jump/flush from the commit side.

---
 rtl/inst_fetcher_pkg.sv | 20 ++
 rtl/inst_fetcher_icache_dm.sv | 47 ++++
 rtl/inst_fetcher.sv | 137 +++++++++++++
 tb/tb_inst_fetcher.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetcher_pkg.sv
// Shared definitions for the instruction fetch stage: bus widths, fetch
// state encodings and the tag/index split derived from the icache size.
package inst_fetcher_pkg;

  localparam int ADDR_W = 32;
  localparam int INST_W = 32;

  typedef enum logic [1:0] {
    FETCH    = 2'd0,
    WAIT_MEM = 2'd1,
    DELIVER  = 2'd2,
    DROP     = 2'd3
  } fetch_state_t;

  // Tag width left over once the byte offset and line index are removed.
  function automatic int tag_w(input int idx_w);
    return ADDR_W - idx_w - 2;
  endfunction

endpackage

// File: rtl/inst_fetcher_icache_dm.sv
// Direct-mapped, one-word-per-line instruction cache.
// Lookup is combinational; tag/data writes and valid clearing are synchronous.
module icache_dm
  import inst_fetcher_pkg::*;
#(
  parameter int IDX_W = 6,
  parameter int TAG_W = ADDR_W - IDX_W - 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [IDX_W-1:0]  rd_idx,
  input  logic [TAG_W-1:0]  rd_tag,
  output logic              hit,
  output logic [INST_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [INST_W-1:0] wr_data
);

  localparam int LINES = 1 << IDX_W;

  logic [LINES-1:0]  valid;
  logic [TAG_W-1:0]  tag_mem  [LINES];
  logic [INST_W-1:0] data_mem [LINES];

  // Valid bits: cleared by reset, set when a line is filled.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else if (wr_en) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage; no reset needed since valid gates every hit.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_mem[wr_idx]  <= wr_tag;
      data_mem[wr_idx] <= wr_data;
    end
  end

  assign hit     = valid[rd_idx] && (tag_mem[rd_idx] == rd_tag);
  assign rd_data = data_mem[rd_idx];

endmodule

// File: rtl/inst_fetcher.sv
// Instruction fetch stage. Holds the PC, issues one fetch at a time to the
// memory controller and pushes {pc, inst} into the instruction queue.
// Define INF_ICACHE_EN to add a direct-mapped icache; without it every
// instruction takes the FETCH -> WAIT_MEM -> DELIVER path.
//
// state    | meaning
// FETCH    | look up pc; push on hit, otherwise issue a memory request
// WAIT_MEM | request outstanding; address held until iMEM_done
// DELIVER  | fetched word held in pend until the queue accepts it
// DROP     | redirect arrived mid-request; wait for done and discard data
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                ICACHE_IDX_W = 6,
  parameter logic [ADDR_W-1:0] RESET_PC     = 32'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  output logic              oMEM_en,
  output logic [ADDR_W-1:0] oMEM_addr,
  input  logic              iMEM_done,
  input  logic [INST_W-1:0] iMEM_inst,
  input  logic              iIQ_full,
  output logic              oIQ_valid,
  output logic [INST_W-1:0] oIQ_inst,
  output logic [ADDR_W-1:0] oIQ_pc,
  input  logic              iJump_en,
  input  logic [ADDR_W-1:0] iJump_pc
);

  localparam int TAG_W = tag_w(ICACHE_IDX_W);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [INST_W-1:0] pend;
  logic              hit;
  logic [INST_W-1:0] hit_data;

`ifdef INF_ICACHE_EN
  logic fill_en;

  // A fill happens only for a request that was not redirected away.
  assign fill_en = rdy && (state == WAIT_MEM) && iMEM_done && !iJump_en;

  icache_dm #(
    .IDX_W (ICACHE_IDX_W),
    .TAG_W (TAG_W)
  ) u_icache (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (pc[ICACHE_IDX_W+1:2]),
    .rd_tag  (pc[ADDR_W-1:ICACHE_IDX_W+2]),
    .hit     (hit),
    .rd_data (hit_data),
    .wr_en   (fill_en),
    .wr_idx  (oMEM_addr[ICACHE_IDX_W+1:2]),
    .wr_tag  (oMEM_addr[ADDR_W-1:ICACHE_IDX_W+2]),
    .wr_data (iMEM_inst)
  );
`else
  assign hit      = 1'b0;
  assign hit_data = '0;
`endif

  // Fetch FSM with registered memory and queue outputs; a jump overrides any push.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      pc        <= RESET_PC;
      pend      <= '0;
      oMEM_en   <= 1'b0;
      oMEM_addr <= '0;
      oIQ_valid <= 1'b0;
      oIQ_inst  <= '0;
      oIQ_pc    <= '0;
    end else if (!rdy) begin
      oIQ_valid <= 1'b0;
    end else begin
      oIQ_valid <= 1'b0;
      if (iJump_en) begin
        pc <= iJump_pc;
      end
      case (state)
        FETCH: begin
          if (iJump_en) begin
            state <= FETCH;
          end else if (hit) begin
            if (!iIQ_full) begin
              oIQ_valid <= 1'b1;
              oIQ_pc    <= pc;
              oIQ_inst  <= hit_data;
              pc        <= pc + 32'd4;
            end
          end else begin
            oMEM_en   <= 1'b1;
            oMEM_addr <= pc;
            state     <= WAIT_MEM;
          end
        end
        WAIT_MEM: begin
          if (iMEM_done) begin
            oMEM_en <= 1'b0;
            if (iJump_en) begin
              state <= FETCH;
            end else begin
              pend  <= iMEM_inst;
              state <= DELIVER;
            end
          end else if (iJump_en) begin
            // memctrl cannot abort, so keep the request up and discard later
            state <= DROP;
          end
        end
        DELIVER: begin
          if (iJump_en) begin
            state <= FETCH;
          end else if (!iIQ_full) begin
            oIQ_valid <= 1'b1;
            oIQ_pc    <= pc;
            oIQ_inst  <= pend;
            pc        <= pc + 32'd4;
            state     <= FETCH;
          end
        end
        DROP: begin
          if (iMEM_done) begin
            oMEM_en <= 1'b0;
            state   <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher with a 4-cycle memory controller model.
`timescale 1ns/1ps
module tb_inst_fetcher;

  localparam int LAT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic        oMEM_en;
  logic [31:0] oMEM_addr;
  logic        iMEM_done = 1'b0;
  logic [31:0] iMEM_inst = 32'h0;
  logic        iIQ_full;
  logic        oIQ_valid;
  logic [31:0] oIQ_inst;
  logic [31:0] oIQ_pc;
  logic        iJump_en;
  logic [31:0] iJump_pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  inst_fetcher #(.ICACHE_IDX_W(6), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .oMEM_en(oMEM_en), .oMEM_addr(oMEM_addr),
    .iMEM_done(iMEM_done), .iMEM_inst(iMEM_inst),
    .iIQ_full(iIQ_full),
    .oIQ_valid(oIQ_valid), .oIQ_inst(oIQ_inst), .oIQ_pc(oIQ_pc),
    .iJump_en(iJump_en), .iJump_pc(iJump_pc)
  );

  // Memory contents: low address bits shifted up, with 0x13 in the low byte.
  function automatic logic [31:0] word_at(input logic [31:0] a);
    return {a[23:0], 8'h13};
  endfunction

  // Memory controller model: snapshots inputs at the edge, acts on the falling edge.
  logic        s_rst, s_rdy, s_en, s_done;
  logic [31:0] s_addr;
  logic        m_busy = 1'b0;
  int          m_cnt  = 0;
  logic [31:0] m_addr = 32'h0;

  always @(posedge clk) begin
    s_rst  = rst;
    s_rdy  = rdy;
    s_en   = oMEM_en;
    s_addr = oMEM_addr;
    s_done = iMEM_done;
  end

  always @(negedge clk) begin
    if (s_rst) begin
      m_busy    = 1'b0;
      iMEM_done = 1'b0;
    end else if (s_rdy) begin
      if (s_done) begin
        iMEM_done = 1'b0;
        m_busy    = 1'b0;
      end else if (m_busy) begin
        if (m_cnt == 0) begin
          iMEM_done = 1'b1;
          iMEM_inst = word_at(m_addr);
        end else begin
          m_cnt = m_cnt - 1;
        end
      end else if (s_en) begin
        m_busy = 1'b1;
        m_cnt  = LAT - 3;
        m_addr = s_addr;
      end
    end
  end

  // Push monitor.
  logic [31:0] pcq[$];
  logic [31:0] instq[$];
  int base = 0;

  always @(negedge clk) begin
    if (oIQ_valid) begin
      pcq.push_back(oIQ_pc);
      instq.push_back(oIQ_inst);
    end
  end

  function automatic int npush();
    return pcq.size() - base;
  endfunction

  function automatic logic [31:0] ppc(input int i);
    return (pcq.size() > base + i) ? pcq[base+i] : 32'hxxxxxxxx;
  endfunction

  function automatic logic [31:0] pinst(input int i);
    return (instq.size() > base + i) ? instq[base+i] : 32'hxxxxxxxx;
  endfunction

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tmo(input string name);
    total++;
    bad++;
    $display("FAIL %s: timed out waiting", name);
  endtask

  task automatic wait_push(input int n, input int budget, input string name);
    int k = 0;
    while (npush() < n && k < budget) begin
      cyc();
      k++;
    end
    if (npush() < n) tmo(name);
  endtask

  task automatic wait_en(input logic val, input int budget, input string name);
    int k = 0;
    while (oMEM_en !== val && k < budget) begin
      cyc();
      k++;
    end
    if (oMEM_en !== val) tmo(name);
  endtask

  // Checks the request stays up with a fixed address until memctrl answers.
  task automatic hold_until_done(input logic [31:0] addr, input string name);
    int k = 0;
    while (!iMEM_done && k < 12) begin
      chk({name, "_en"}, {31'h0, oMEM_en}, 32'h1);
      chk({name, "_addr"}, oMEM_addr, addr);
      cyc();
      k++;
    end
    if (!iMEM_done) tmo(name);
  endtask

  task automatic do_jump(input logic [31:0] target);
    base     = pcq.size();
    iJump_en = 1'b1;
    iJump_pc = target;
    cyc();
    iJump_en = 1'b0;
  endtask

  typedef struct {
    logic [31:0] jpc;
    logic [31:0] pc0;
    logic [31:0] in0;
    logic [31:0] pc1;
    logic [31:0] in1;
  } vec_t;

  vec_t vt[5];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h0000_0100, 32'h0000_0100, 32'h0001_0013, 32'h0000_0104, 32'h0001_0413};
    vt[1] = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'hFFFF_FC13, 32'h0000_0000, 32'h0000_0013};
    vt[2] = '{32'h0000_0040, 32'h0000_0040, 32'h0000_4013, 32'h0000_0044, 32'h0000_4413};
    vt[3] = '{32'h0000_1000, 32'h0000_1000, 32'h0010_0013, 32'h0000_1004, 32'h0010_0413};
    vt[4] = '{32'h0000_0202, 32'h0000_0202, 32'h0002_0213, 32'h0000_0206, 32'h0002_0613};

    rst = 1'b1; rdy = 1'b1; iIQ_full = 1'b0; iJump_en = 1'b0; iJump_pc = 32'h0;
    repeat (3) cyc();
    chk("rst_mem_en", {31'h0, oMEM_en}, 32'h0);
    chk("rst_mem_addr", oMEM_addr, 32'h0);
    chk("rst_iq_valid", {31'h0, oIQ_valid}, 32'h0);
    chk("rst_iq_inst", oIQ_inst, 32'h0);
    chk("rst_iq_pc", oIQ_pc, 32'h0);

    // First fetch from RESET_PC.
    base = pcq.size();
    rst  = 1'b0;
    cyc();
    hold_until_done(32'h0, "req0");
    cyc();
    chk("req0_drop", {31'h0, oMEM_en}, 32'h0);
    wait_push(1, 5, "push0");
    chk("push0_pc", ppc(0), 32'h0);
    chk("push0_inst", pinst(0), 32'h0000_0013);
    wait_en(1'b1, 5, "req4");
    chk("req4_addr", oMEM_addr, 32'h4);

`ifdef INF_ICACHE_EN
    // Refetch of a filled line must be served without a memory access.
    wait_push(6, 80, "fill_0_14");
    chk("fill_last_pc", ppc(5), 32'h14);
    do_jump(32'h10);
    for (int k = 0; k < 4 && npush() == 0; k++) begin
      chk("loop_no_mem", {31'h0, oMEM_en}, 32'h0);
      cyc();
    end
    chk("loop_pc", ppc(0), 32'h10);
    chk("loop_inst", pinst(0), 32'h0000_1013);
    // Jump in the cycle a hit for 0x14 would push.
    do_jump(32'h300);
    chk("hitjump_nopush", npush(), 32'h0);
    wait_push(1, 20, "hitjump_push");
    chk("hitjump_pc", ppc(0), 32'h300);
    chk("hitjump_inst", pinst(0), 32'h0003_0013);
`endif

    // Queue full for 5 cycles while a fetched word waits in DELIVER.
    do_jump(32'h800);
    wait_push(1, 30, "full_first");
    chk("full_first_pc", ppc(0), 32'h800);
    iIQ_full = 1'b1;
    wait_en(1'b1, 5, "full_req");
    wait_en(1'b0, 10, "full_done");
    repeat (5) cyc();
    chk("full_nopush", npush(), 32'h1);
    iIQ_full = 1'b0;
    cyc();
    cyc();
    chk("full_onepush", npush(), 32'h2);
    chk("full_pc", ppc(1), 32'h804);
    chk("full_inst", pinst(1), 32'h0008_0413);

    // Jump to 0x200 while the request for 0x8 is in flight.
    rst = 1'b1;
    cyc();
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 40 && !(oMEM_en && oMEM_addr == 32'h8); k++) cyc();
    if (!(oMEM_en && oMEM_addr == 32'h8)) tmo("req8");
    do_jump(32'h200);
    hold_until_done(32'h8, "drop8");
    cyc();
    chk("drop8_fall", {31'h0, oMEM_en}, 32'h0);
    chk("drop8_nopush", npush(), 32'h0);
    wait_en(1'b1, 5, "req200");
    chk("req200_addr", oMEM_addr, 32'h200);
    wait_push(1, 20, "push200");
    chk("push200_pc", ppc(0), 32'h200);
    chk("push200_inst", pinst(0), 32'h0002_0013);
    // The dropped word must not have been cached: 0x8 goes to memory again.
    do_jump(32'h8);
    wait_en(1'b1, 5, "refetch8");
    chk("refetch8_addr", oMEM_addr, 32'h8);
    wait_push(1, 20, "push8");
    chk("push8_pc", ppc(0), 32'h8);
    chk("push8_inst", pinst(0), 32'h0000_0813);

    // Freeze for 3 cycles mid-request.
    wait_en(1'b1, 10, "frz_req");
    begin
      logic [31:0] a;
      a   = oMEM_addr;
      rdy = 1'b0;
      for (int k = 0; k < 3; k++) begin
        cyc();
        chk("frz_en", {31'h0, oMEM_en}, 32'h1);
        chk("frz_addr", oMEM_addr, a);
        chk("frz_iq_valid", {31'h0, oIQ_valid}, 32'h0);
      end
      rdy  = 1'b1;
      base = pcq.size();
      wait_push(1, 20, "frz_push");
      chk("frz_push_pc", ppc(0), a);
      chk("frz_push_inst", pinst(0), word_at(a));
    end
    // Freeze right after a push: the strobe must not repeat.
    rdy = 1'b0;
    cyc();
    chk("frz_pulse0", {31'h0, oIQ_valid}, 32'h0);
    cyc();
    chk("frz_pulse1", {31'h0, oIQ_valid}, 32'h0);
    rdy = 1'b1;
    cyc();
    chk("frz_nodup", npush(), 32'h1);

    // Reset mid-request.
    wait_en(1'b1, 10, "rst_req");
    rst = 1'b1;
    cyc();
    chk("rstmid_en", {31'h0, oMEM_en}, 32'h0);
    chk("rstmid_addr", oMEM_addr, 32'h0);
    chk("rstmid_valid", {31'h0, oIQ_valid}, 32'h0);
    rst  = 1'b0;
    base = pcq.size();
    cyc();
    chk("rstmid_miss_en", {31'h0, oMEM_en}, 32'h1);
    chk("rstmid_miss_addr", oMEM_addr, 32'h0);
    wait_push(1, 20, "rstmid_push");
    chk("rstmid_push_pc", ppc(0), 32'h0);

    // Redirect table: two consecutive pushes after each jump.
    for (int i = 0; i < 5; i++) begin
      do_jump(vt[i].jpc);
      wait_push(2, 60, "vec_push");
      chk($sformatf("vec%0d_pc0", i), ppc(0), vt[i].pc0);
      chk($sformatf("vec%0d_in0", i), pinst(0), vt[i].in0);
      chk($sformatf("vec%0d_pc1", i), ppc(1), vt[i].pc1);
      chk($sformatf("vec%0d_in1", i), pinst(1), vt[i].in1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
